// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that walks one 4-bit CLA slice across the operands, LS nibble first.
// Optional macro ADD_OVERFLOW_FLAG_EN adds a registered signed-overflow output ovf_o.

module cla_adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p    = a_i ^ b_i;
  assign w_g    = a_i & b_i;
  assign w_c[0] = cin_i;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign sum_o  = w_p ^ w_c[3:0];
  assign cout_o = w_c[4];
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid_o and the result stay stable until that edge, and ready_o is high only in IDLE.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef ADD_OVERFLOW_FLAG_EN
  ,
  output logic             ovf_o
`endif
);
  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_accept;
  logic             w_last;

  assign w_a_nib  = r_a[{r_cnt, 2'b00} +: 4];
  assign w_b_nib  = r_b[{r_cnt, 2'b00} +: 4];
  assign w_accept = (r_state == IDLE) && valid_i;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  cla_adder_4bit u_slice (
    .a_i    (w_a_nib),
    .b_i    (w_b_nib),
    .cin_i  (r_carry),
    .sum_o  (w_slice_sum),
    .cout_o (w_slice_cout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) w_next = RUN;
      end
      RUN: begin
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a_i;
      r_b     <= b_i;
      r_carry <= cin_i;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum[{r_cnt, 2'b00} +: 4] <= w_slice_sum;
      r_carry                    <= w_slice_cout;
      if (w_last) r_cout <= w_slice_cout;
      else        r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign sum_o  = r_sum;
  assign cout_o = r_cout;

`ifdef ADD_OVERFLOW_FLAG_EN
  logic r_ovf;
  logic w_msb_cin;

  // Carry into the MSB is recovered from the top bit of the final nibble: a ^ b ^ sum.
  assign w_msb_cin = w_a_nib[3] ^ w_b_nib[3] ^ w_slice_sum[3];

  always_ff @(posedge clk_i) begin
    if (rst_i)       r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_msb_cin ^ w_slice_cout;
  end

  assign ovf_o = r_ovf;
`endif
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=32): scoreboard queue, latency and protocol checks.
// Build with ADD_OVERFLOW_FLAG_EN defined to also check ovf_o.

module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic             clk_i;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
`ifdef ADD_OVERFLOW_FLAG_EN
  logic             ovf_o;
`endif

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .cout_o  (cout_o)
`ifdef ADD_OVERFLOW_FLAG_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH+1:0] exp_q[$];   // {ovf, cout, sum}
  int               lat_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  bit               rand_ready = 1'b0;
  logic             prev_valid = 1'b0;
  bit               chk_idle = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c);
    logic [WIDTH:0] s;
    logic           ovf;
    s   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`ifdef ADD_OVERFLOW_FLAG_EN
    return {ovf, s};
`else
    return {1'b0, s};
`endif
  endfunction

  initial forever begin
    logic [WIDTH+1:0] e;
    @(negedge clk_i);
    if (rst_i) begin
      prev_valid = 1'b0;
      chk_idle   = 1'b0;
    end else begin
      if (chk_idle) begin
        chk("post_hs_valid", 64'(valid_o), 64'd0);
        chk("post_hs_ready", 64'(ready_o), 64'd1);
        chk_idle = 1'b0;
      end
      if (valid_i && ready_o) lat_q.push_back(cyc + 1);
      if (valid_o && !prev_valid) begin
        if (lat_q.size() == 0) chk("latency_noacc", 64'd1, 64'd0);
        else                   chk("latency", 64'(cyc - lat_q.pop_front()), 64'(NIB));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", 64'(sum_o), 64'(e[WIDTH-1:0]));
          chk("cout", 64'(cout_o), 64'(e[WIDTH]));
`ifdef ADD_OVERFLOW_FLAG_EN
          chk("ovf", 64'(ovf_o), 64'(e[WIDTH+1]));
`endif
          chk_idle = 1'b1;
        end
      end
      prev_valid = valid_o;
    end
  end

  // ---------------- drivers ----------------
  initial forever begin
    @(posedge clk_i);
    #1;
    if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    int n = 0;
    a_i     = a;
    b_i     = b;
    cin_i   = c;
    valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'(ready_o), 64'd1);
        break;
      end
    end
    exp_q.push_back(model(a, b, c));
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    cin_i   = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a_i     = '0;
    b_i     = '0;
    cin_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_sum", 64'(sum_o), 64'd0);
    chk("rst_cout", 64'(cout_o), 64'd0);
`ifdef ADD_OVERFLOW_FLAG_EN
    chk("rst_ovf", 64'(ovf_o), 64'd0);
`endif
    @(posedge clk_i);
    #1;

    // Directed vectors: full ripple, carry-in, signed overflow.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    drain();
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    drain();

    // Busy rejection: second request held valid throughout RUN/DONE of the first.
    send(32'h0000_0001, 32'h0000_0001, 1'b0);
    send(32'h0000_0005, 32'h0000_0003, 1'b0);
    drain();

    // Backpressure: hold result for 5 cycles.
    ready_i = 1'b0;
    send(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
    begin
      int n = 0;
      while (!valid_o && n < 50) begin
        @(negedge clk_i);
        n++;
      end
      chk("bp_valid_rise", 64'(valid_o), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_valid", 64'(valid_o), 64'd1);
      chk("bp_ready", 64'(ready_o), 64'd0);
      chk("bp_sum", 64'(sum_o), 64'h0000_0000);
      chk("bp_cout", 64'(cout_o), 64'd1);
    end
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    drain();

    // Reset while RUN holds cnt=3: operation must vanish.
    send(32'h1111_1111, 32'h2222_2222, 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_valid", 64'(valid_o), 64'd0);
    chk("abort_ready", 64'(ready_o), 64'd1);
    chk("abort_sum", 64'(sum_o), 64'd0);
    chk("abort_cout", 64'(cout_o), 64'd0);
    repeat (20) @(negedge clk_i);
    @(posedge clk_i);
    #1;

    // Random back-to-back traffic with random consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
    rand_ready = 1'b0;
    ready_i    = 1'b1;
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
